memory_io_responder: RTL

MEMORY_IO_RESPONDER -- requirements
Module: memory_io_responder

---
 rtl/memory_io_responder_if.sv | 42 ++++
 rtl/memory_io_responder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/memory_io_responder_if.sv
// ---------------------------------------------------------------------------
// memory_io_responder_if : CPU, RAM, keyboard and display signals of the
// memory/IO responder.  Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface memory_io_responder_if;
  logic [15:0] Addr;
  logic [15:0] Data_W;
  logic        MIO_EN;
  logic        R_W;
  logic [15:0] Data_R;
  logic        R;
  logic        Mem_Req;
  logic        Mem_WE;
  logic [15:0] Mem_Addr;
  logic [15:0] Mem_WData;
  logic        Mem_Ack;
  logic [15:0] Mem_RData;
  logic        Kbd_Valid;
  logic [7:0]  Kbd_Data;
  logic        Disp_Valid;
  logic [7:0]  Disp_Data;
  logic        Disp_Ready;
  logic        Err;

  modport slave (
    input  Addr, Data_W, MIO_EN, R_W, Mem_Ack, Mem_RData,
           Kbd_Valid, Kbd_Data, Disp_Ready,
    output Data_R, R, Mem_Req, Mem_WE, Mem_Addr, Mem_WData,
           Disp_Valid, Disp_Data, Err
  );

  modport master (
    output Addr, Data_W, MIO_EN, R_W, Mem_Ack, Mem_RData,
           Kbd_Valid, Kbd_Data, Disp_Ready,
    input  Data_R, R, Mem_Req, Mem_WE, Mem_Addr, Mem_WData,
           Disp_Valid, Disp_Data, Err
  );
endinterface

`default_nettype wire

// File: rtl/memory_io_responder.sv
// ---------------------------------------------------------------------------
// memory_io_responder : routes CPU accesses to RAM (with timeout) or to the
// keyboard/display registers at 0xFE00 and up.  Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module memory_io_responder #(
  parameter int TIMEOUT = 255
) (
  input  logic                  Clk,
  input  logic                  Reset,
  memory_io_responder_if.slave  io
);

  localparam int          CNT_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [15:0] MMIO_BASE = 16'hFE00;
  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    RESP = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      addr_q, addr_d;
  logic [15:0]      wdata_q, wdata_d;
  logic             rw_q, rw_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             r_q, r_d;
  logic [15:0]      data_r_q, data_r_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [15:0]      mem_addr_q, mem_addr_d;
  logic [15:0]      mem_wdata_q, mem_wdata_d;
  logic             err_q, err_d;
  logic             krdy_q, krdy_d;
  logic [7:0]       kbd_byte_q, kbd_byte_d;
  logic             drdy_q, drdy_d;
  logic             disp_valid_q, disp_valid_d;
  logic [7:0]       disp_data_q, disp_data_d;

  logic             kbdr_rd;
  logic             ddr_wr;

  // Register side effects happen in RESP, the same cycle R is being set up.
  assign kbdr_rd = (state_q == RESP) && !rw_q && (addr_q == KBDR_ADDR);
  assign ddr_wr  = (state_q == RESP) &&  rw_q && (addr_q == DDR_ADDR);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rw_d        = rw_q;
    cnt_d       = cnt_q;
    r_d         = 1'b0;
    data_r_d    = data_r_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        if (io.MIO_EN) begin
          addr_d  = io.Addr;
          wdata_d = io.Data_W;
          rw_d    = io.R_W;
          if (io.Addr >= MMIO_BASE) begin
            state_d = RESP;
          end else begin
            state_d     = MEM;
            mem_req_d   = 1'b1;
            mem_we_d    = io.R_W;
            mem_addr_d  = io.Addr;
            mem_wdata_d = io.Data_W;
            cnt_d       = '0;
          end
        end
      end
      MEM: begin
        // A late acknowledge on the final counted cycle still wins.
        if (io.Mem_Ack) begin
          mem_req_d = 1'b0;
          if (!rw_q) data_r_d = io.Mem_RData;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          mem_req_d = 1'b0;
          if (!rw_q) data_r_d = 16'hFFFF;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        r_d     = 1'b1;
        state_d = HOLD;
        if (!rw_q && (addr_q >= MMIO_BASE)) begin
          case (addr_q)
            KBSR_ADDR: data_r_d = {krdy_q, 15'b0};
            KBDR_ADDR: data_r_d = {8'h00, kbd_byte_q};
            DSR_ADDR:  data_r_d = {drdy_q, 15'b0};
            default:   data_r_d = 16'h0000;
          endcase
        end
      end
      HOLD: begin
        if (!io.MIO_EN) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    krdy_d       = krdy_q;
    kbd_byte_d   = kbd_byte_q;
    drdy_d       = drdy_q;
    disp_valid_d = disp_valid_q;
    disp_data_d  = disp_data_q;

    if (kbdr_rd) krdy_d = 1'b0;
    // A byte arriving as KBDR is read refills the freshly emptied slot.
    if (io.Kbd_Valid && (!krdy_q || kbdr_rd)) begin
      kbd_byte_d = io.Kbd_Data;
      krdy_d     = 1'b1;
    end

    if (disp_valid_q && io.Disp_Ready) begin
      disp_valid_d = 1'b0;
      drdy_d       = 1'b1;
    end else if (ddr_wr && drdy_q) begin
      disp_data_d  = wdata_q[7:0];
      disp_valid_d = 1'b1;
      drdy_d       = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= IDLE;
      addr_q       <= 16'h0000;
      wdata_q      <= 16'h0000;
      rw_q         <= 1'b0;
      cnt_q        <= '0;
      r_q          <= 1'b0;
      data_r_q     <= 16'h0000;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 16'h0000;
      mem_wdata_q  <= 16'h0000;
      err_q        <= 1'b0;
      krdy_q       <= 1'b0;
      kbd_byte_q   <= 8'h00;
      drdy_q       <= 1'b1;
      disp_valid_q <= 1'b0;
      disp_data_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rw_q         <= rw_d;
      cnt_q        <= cnt_d;
      r_q          <= r_d;
      data_r_q     <= data_r_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      err_q        <= err_d;
      krdy_q       <= krdy_d;
      kbd_byte_q   <= kbd_byte_d;
      drdy_q       <= drdy_d;
      disp_valid_q <= disp_valid_d;
      disp_data_q  <= disp_data_d;
    end
  end

  assign io.R          = r_q;
  assign io.Data_R     = data_r_q;
  assign io.Mem_Req    = mem_req_q;
  assign io.Mem_WE     = mem_we_q;
  assign io.Mem_Addr   = mem_addr_q;
  assign io.Mem_WData  = mem_wdata_q;
  assign io.Err        = err_q;
  assign io.Disp_Valid = disp_valid_q;
  assign io.Disp_Data  = disp_data_q;

endmodule

`default_nettype wire
